vc_out_port_mux: RTL
====================

Name: vc_out_port_mux

Overview:
- Parametrised output stage for one router output port in the hypercube NoC.
- Selects one of NUM_IN input flit streams with a one-hot select driven by the switch allocator.
- Buffers the selected flit in a 2-entry output FIFO.
- Releases flits downstream only when the flit's virtual channel holds a credit; per-VC credit counters track downstream buffer space.

Parameters:
- NUM_IN, 5, number of input ports (one-hot select width).
- DATA_W, 32, flit data width.
- VCH_W, 2, VC id width; NUM_VC = 2**VCH_W.
- CREDIT_INIT, 4, downstream buffer depth per VC; reset and maximum credit value.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- idata  in  NUM_IN*DATA_W  packed input flits; port i at bits [i*DATA_W +: DATA_W].
- ivalid  in  NUM_IN  per-input valid.
- ivch  in  NUM_IN*VCH_W  packed per-input VC id.
- sel  in  NUM_IN  one-hot select from the allocator.
- iready  out  1  FIFO can accept a flit this cycle.
- odata  out  DATA_W  flit at the FIFO head.
- ovalid  out  1  flit sent downstream this cycle.
- ovch  out  VCH_W  VC id of the head flit.
- credit_in  in  NUM_VC  one-cycle pulse per VC; downstream freed one slot.
- err  out  2  sticky error flags; bit0 = multi-hot select, bit1 = credit overflow.

Behaviour:
- Reset (async, rst_n=0): FIFO empty, head/tail entries zero, odata=0, ovch=0, ovalid=0, iready=1, all credits = CREDIT_INIT, err=0. Reset mid-transfer discards buffered flits.
- Select decode:
  - Legal sel is exactly one bit set; that input is chosen.
  - sel==0: no push, no error.
  - sel multi-hot: no push. If any ivalid bit under sel is 1, set err[0] (sticky until reset).
- Push: legal sel & chosen ivalid & iready; writes {data, vch} to the FIFO tail on the clk edge.
- iready = (count < 2), purely from registered state.
- Pop/ovalid: ovalid = (count > 0) & (credit[head vch] > 0), combinational from registered state. A pop occurs every cycle ovalid=1; there is no downstream ready, credits are the flow control.
- odata/ovch show the head entry whenever count > 0; they hold the last popped value when empty.
- Latency: a flit pushed at edge t appears at ovalid no earlier than cycle t+1. No bypass.
- Push and pop in the same cycle with count=1: count stays 1, order preserved.
- Push and pop with count=2: impossible, since iready=0.
- Credits, each VC counter, range 0..CREDIT_INIT:
  - Decrement on a pop of that VC.
  - Increment on credit_in[v].
  - Decrement and increment of the same VC in the same cycle: unchanged.
  - Increment at CREDIT_INIT without a decrement: counter holds, err[1] set.
- Credit at 0 for the head VC: ovalid=0 and the FIFO stalls (head-of-line blocking is accepted). Flits of other VCs behind it wait.
- FIFO: 2 entries, circular read/write pointers (1 bit each, wrap 1->0), count 0..2.

Optional Feature:
- Macro OUT_MUX_FLIT_CNT_EN.
- Defined: adds output port flit_cnt, 32 bits. It counts pops (ovalid=1 cycles), wraps 0xFFFFFFFF->0, and resets to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then sel=5'b00100, ivalid[2]=1, ivch_2=2'd1, idata_2=32'hA5A5_0001 for one cycle -> next cycle ovalid=1, odata=32'hA5A5_0001, ovch=1; credit[1] drops 4->3.
- Push 5 flits on VC0 with no credit_in -> exactly 4 ovalid pulses. After 2 are buffered, iready=0. Fifth flit stays at head with ovalid=0 until a credit_in[0] pulse, then ovalid=1 next cycle.
- sel=5'b00011 with ivalid[0]=1 -> no push, FIFO count unchanged, err=2'b01 and stays set. sel=0 with ivalid all 1 -> no push, err unchanged.
- Same-cycle pop on VC2 and credit_in[2] at credit 2 -> credit stays 2. credit_in[3] at credit 4 -> credit stays 4, err[1]=1.
- Back-to-back pushes from inputs 0,1,4 with ample credit -> outputs emerge in push order on consecutive cycles. Deassert rst_n mid-stream -> ovalid=0 immediately, credits back to 4.
- With OUT_MUX_FLIT_CNT_EN defined -> after the sequence above, flit_cnt equals the number of ovalid cycles. Counter preloaded near 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/vc_out_port_mux.sv
// Output port stage: one-hot input select, 2-entry FIFO, per-VC credit gating.
// Optional pop counter port flit_cnt when OUT_MUX_FLIT_CNT_EN is defined.
module vc_out_port_mux #(
    parameter int NUM_IN      = 5,
    parameter int DATA_W      = 32,
    parameter int VCH_W       = 2,
    parameter int CREDIT_INIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN*DATA_W-1:0] idata,
    input  logic [NUM_IN-1:0]        ivalid,
    input  logic [NUM_IN*VCH_W-1:0]  ivch,
    input  logic [NUM_IN-1:0]        sel,
    output logic                     iready,
    output logic [DATA_W-1:0]        odata,
    output logic                     ovalid,
    output logic [VCH_W-1:0]         ovch,
    input  logic [(2**VCH_W)-1:0]    credit_in,
    output logic [1:0]               err
`ifdef OUT_MUX_FLIT_CNT_EN
    ,
    output logic [31:0]              flit_cnt
`endif
);

    localparam int NUM_VC = 2**VCH_W;
    localparam int CW = $clog2(CREDIT_INIT + 1);
    localparam logic [CW-1:0] CMAX = CW'(CREDIT_INIT);

    logic [DATA_W-1:0] fifo_data [2];
    logic [VCH_W-1:0]  fifo_vch  [2];
    logic              wptr;
    logic              rptr;
    logic [1:0]        count;
    logic [DATA_W-1:0] last_data;
    logic [VCH_W-1:0]  last_vch;
    logic [CW-1:0]     credit [NUM_VC];
    logic [1:0]        err_q;

    logic              sel_multi;
    logic              sel_onehot;
    logic              sel_vld;
    logic [DATA_W-1:0] mux_data;
    logic [VCH_W-1:0]  mux_vch;
    logic              push;
    logic              pop;
    logic [VCH_W-1:0]  head_vch;
    logic [NUM_VC-1:0] dec;
    logic [NUM_VC-1:0] full;
    logic              ovf;

    always_comb begin
        mux_data = '0;
        mux_vch  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel[i]) begin
                mux_data = mux_data | idata[i*DATA_W +: DATA_W];
                mux_vch  = mux_vch | ivch[i*VCH_W +: VCH_W];
            end
        end
    end

    assign sel_multi  = |(sel & (sel - NUM_IN'(1)));
    assign sel_onehot = (sel != '0) && !sel_multi;
    assign sel_vld    = |(sel & ivalid);

    assign iready   = (count != 2'd2);
    assign push     = sel_onehot && sel_vld && iready;
    assign head_vch = fifo_vch[rptr];
    assign ovalid   = (count != 2'd0) && (credit[head_vch] != '0);
    assign pop      = ovalid;

    // When empty, outputs keep the last flit that left rather than stale RAM.
    assign odata = (count != 2'd0) ? fifo_data[rptr] : last_data;
    assign ovch  = (count != 2'd0) ? head_vch : last_vch;
    assign err   = err_q;

    always_comb begin
        dec  = '0;
        full = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            dec[v]  = pop && (head_vch == VCH_W'(v));
            full[v] = (credit[v] == CMAX);
        end
    end

    assign ovf = |(credit_in & ~dec & full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_vch[0]  <= '0;
            fifo_vch[1]  <= '0;
            wptr         <= 1'b0;
            rptr         <= 1'b0;
            count        <= 2'd0;
            last_data    <= '0;
            last_vch     <= '0;
        end else begin
            if (push) begin
                fifo_data[wptr] <= mux_data;
                fifo_vch[wptr]  <= mux_vch;
                wptr            <= ~wptr;
            end
            if (pop) begin
                rptr      <= ~rptr;
                last_data <= fifo_data[rptr];
                last_vch  <= head_vch;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                credit[v] <= CMAX;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (credit_in[v] && !dec[v]) begin
                    if (!full[v]) begin
                        credit[v] <= credit[v] + CW'(1);
                    end
                end else if (dec[v] && !credit_in[v]) begin
                    credit[v] <= credit[v] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 2'b00;
        end else begin
            if (sel_multi && sel_vld) begin
                err_q[0] <= 1'b1;
            end
            if (ovf) begin
                err_q[1] <= 1'b1;
            end
        end
    end

`ifdef OUT_MUX_FLIT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_cnt <= '0;
        end else if (pop) begin
            flit_cnt <= flit_cnt + 32'd1;
        end
    end
`endif

endmodule
